fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch FSM: takes a PC from writeback, reads instruction memory,
// and hands the word to decode. Exactly one fetch in flight; sticky error on memory timeout.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_unit #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_pc_valid,
  input  logic [`ADDRESS_WIDTH-1:0] i_pc,
  output logic                      o_pc_ack,
  output logic                      o_mem_rd,
  output logic [`ADDRESS_WIDTH-1:0] o_mem_addr,
  input  logic                      i_mem_valid,
  input  logic [`DATA_WIDTH-1:0]    i_mem_data,
  output logic                      o_inst_valid,
  output logic [`DATA_WIDTH-1:0]    o_inst,
  output logic [`ADDRESS_WIDTH-1:0] o_inst_pc,
  input  logic                      i_dec_ready,
  output logic                      o_ready,
  output logic                      o_err
);

  localparam int unsigned AW = `ADDRESS_WIDTH;
  localparam int unsigned DW = `DATA_WIDTH;
  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          flush_q, flush_d;
  logic [7:0]    count_q, count_d;
  logic [DW-1:0] inst_q, inst_d;
  logic [AW-1:0] inst_pc_q, inst_pc_d;
  logic          err_q, err_d;
  logic          pc_ack_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flush_d   = flush_q;
    count_d   = count_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_pc_valid) begin
          pc_d    = i_pc;
          state_d = StReq;
        end
      end
      StReq: begin
        count_d = '0;
        state_d = StWait;
        // The read issued this cycle targets the stale PC, so its return must be dropped.
        if (i_pc_valid) begin
          pc_d    = i_pc;
          flush_d = 1'b1;
        end
      end
      StWait: begin
        count_d = count_q + 8'd1;
        if (i_pc_valid) pc_d = i_pc;
        if (i_mem_valid) begin
          if (flush_q || i_pc_valid) begin
            flush_d = 1'b0;
            state_d = StReq;
          end else begin
            inst_d    = i_mem_data;
            inst_pc_d = pc_q;
            state_d   = StOut;
          end
        end else if (count_q == TimeoutLast) begin
          err_d   = 1'b1;
          flush_d = 1'b0;
          state_d = StIdle;
        end else if (i_pc_valid) begin
          flush_d = 1'b1;
        end
      end
      StOut: begin
        // A redirect wins over the sequential increment whether or not decode accepts.
        if (i_pc_valid) begin
          pc_d    = i_pc;
          state_d = StReq;
        end else if (i_dec_ready) begin
          pc_d    = pc_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      flush_q   <= 1'b0;
      count_q   <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      err_q     <= 1'b0;
      pc_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flush_q   <= flush_d;
      count_q   <= count_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      err_q     <= err_d;
      pc_ack_q  <= i_pc_valid;
    end
  end

  assign o_pc_ack     = pc_ack_q;
  assign o_mem_rd     = (state_q == StReq);
  assign o_mem_addr   = pc_q;
  assign o_inst_valid = (state_q == StOut);
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;
  assign o_ready      = (state_q == StIdle);
  assign o_err        = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: basic fetch, backpressure, redirects, timeout, wrap and reset.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_fetch_unit;

  localparam int unsigned TO = 5;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      i_pc_valid;
  logic [`ADDRESS_WIDTH-1:0] i_pc;
  logic                      o_pc_ack;
  logic                      o_mem_rd;
  logic [`ADDRESS_WIDTH-1:0] o_mem_addr;
  logic                      i_mem_valid;
  logic [`DATA_WIDTH-1:0]    i_mem_data;
  logic                      o_inst_valid;
  logic [`DATA_WIDTH-1:0]    o_inst;
  logic [`ADDRESS_WIDTH-1:0] o_inst_pc;
  logic                      i_dec_ready;
  logic                      o_ready;
  logic                      o_err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_pc_valid   (i_pc_valid),
    .i_pc         (i_pc),
    .o_pc_ack     (o_pc_ack),
    .o_mem_rd     (o_mem_rd),
    .o_mem_addr   (o_mem_addr),
    .i_mem_valid  (i_mem_valid),
    .i_mem_data   (i_mem_data),
    .o_inst_valid (o_inst_valid),
    .o_inst       (o_inst),
    .o_inst_pc    (o_inst_pc),
    .i_dec_ready  (i_dec_ready),
    .o_ready      (o_ready),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IDLE -> REQ -> WAIT -> OUT with memory answering on the first WAIT cycle.
  task automatic fetch_to_out(input logic [31:0] pc, input logic [31:0] data);
    i_pc_valid = 1'b1;
    i_pc       = pc;
    step();
    i_pc_valid = 1'b0;
    step();
    i_mem_valid = 1'b1;
    i_mem_data  = data;
    step();
    i_mem_valid = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    i_pc_valid  = 1'b0;
    i_pc        = '0;
    i_mem_valid = 1'b0;
    i_mem_data  = '0;
    i_dec_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_ready", o_ready, 1);
    check("rst_inst_valid", o_inst_valid, 0);
    check("rst_mem_rd", o_mem_rd, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_err", o_err, 0);
    check("rst_pc_ack", o_pc_ack, 0);

    // Basic fetch, memory returns after 3 WAIT cycles, decode always ready.
    i_dec_ready = 1'b1;
    i_pc_valid  = 1'b1;
    i_pc        = 32'h10;
    step();
    i_pc_valid = 1'b0;
    check("basic_pc_ack", o_pc_ack, 1);
    check("basic_mem_rd", o_mem_rd, 1);
    check("basic_mem_addr", o_mem_addr, 32'h10);
    check("basic_ready_busy", o_ready, 0);
    step();
    check("basic_rd_one_cycle", o_mem_rd, 0);
    check("basic_ack_one_cycle", o_pc_ack, 0);
    step();
    step();
    i_mem_valid = 1'b1;
    i_mem_data  = 32'hA5;
    step();
    i_mem_valid = 1'b0;
    check("basic_inst_valid", o_inst_valid, 1);
    check("basic_inst", o_inst, 32'hA5);
    check("basic_inst_pc", o_inst_pc, 32'h10);
    step();
    check("basic_valid_drop", o_inst_valid, 0);
    check("basic_idle", o_ready, 1);
    check("basic_pc_inc", dut.pc_q, 32'h11);

    // Decode backpressure for 5 cycles.
    i_dec_ready = 1'b0;
    fetch_to_out(32'h30, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", o_inst_valid, 1);
      check("bp_inst_held", o_inst, 32'h1234_5678);
      step();
    end
    i_dec_ready = 1'b1;
    check("bp_still_valid", o_inst_valid, 1);
    step();
    i_dec_ready = 1'b0;
    check("bp_transfer", o_inst_valid, 0);
    check("bp_idle", o_ready, 1);
    check("bp_pc_inc", dut.pc_q, 32'h31);

    // Redirect in WAIT one cycle before the memory return.
    i_pc_valid = 1'b1;
    i_pc       = 32'h40;
    step();
    i_pc_valid = 1'b0;
    step();
    i_pc_valid = 1'b1;
    i_pc       = 32'h20;
    step();
    i_pc_valid = 1'b0;
    check("redir_ack", o_pc_ack, 1);
    check("redir_still_wait", o_ready | o_mem_rd | o_inst_valid, 0);
    i_mem_valid = 1'b1;
    i_mem_data  = 32'hDEAD;
    step();
    i_mem_valid = 1'b0;
    check("redir_ack_once", o_pc_ack, 0);
    check("redir_discard", o_inst_valid, 0);
    check("redir_rd", o_mem_rd, 1);
    check("redir_addr", o_mem_addr, 32'h20);
    step();
    i_mem_valid = 1'b1;
    i_mem_data  = 32'hBEEF;
    step();
    i_mem_valid = 1'b0;
    check("redir_inst", o_inst, 32'hBEEF);
    check("redir_inst_pc", o_inst_pc, 32'h20);

    // Redirect in OUT without decode accepting: instruction dropped, refetch at new PC.
    i_pc_valid = 1'b1;
    i_pc       = 32'h70;
    step();
    i_pc_valid = 1'b0;
    check("out_redir_drop", o_inst_valid, 0);
    check("out_redir_rd", o_mem_rd, 1);
    check("out_redir_addr", o_mem_addr, 32'h70);

    // Redirect coinciding with the memory return in WAIT.
    step();
    i_pc_valid  = 1'b1;
    i_pc        = 32'h60;
    i_mem_valid = 1'b1;
    i_mem_data  = 32'h55;
    step();
    i_pc_valid  = 1'b0;
    i_mem_valid = 1'b0;
    check("coin_discard", o_inst_valid, 0);
    check("coin_addr", o_mem_addr, 32'h60);
    check("coin_rd", o_mem_rd, 1);
    step();
    i_mem_valid = 1'b1;
    i_mem_data  = 32'h77;
    step();
    i_mem_valid = 1'b0;
    check("coin_inst_pc", o_inst_pc, 32'h60);
    i_dec_ready = 1'b1;
    step();
    i_dec_ready = 1'b0;
    check("coin_idle", o_ready, 1);

    // Timeout: exactly TO cycles in WAIT, then sticky error.
    i_pc_valid = 1'b1;
    i_pc       = 32'h80;
    step();
    i_pc_valid = 1'b0;
    step();
    repeat (TO - 1) step();
    check("to_not_yet", o_err, 0);
    check("to_still_wait", o_ready, 0);
    step();
    check("to_err", o_err, 1);
    check("to_idle", o_ready, 1);
    i_mem_valid = 1'b1;
    i_mem_data  = 32'h99;
    step();
    i_mem_valid = 1'b0;
    check("to_late_ignored", o_inst_valid, 0);
    check("to_late_idle", o_ready, 1);
    step();
    check("to_sticky", o_err, 1);

    // Wrap-around of the sequential PC.
    i_dec_ready = 1'b0;
    fetch_to_out(32'hFFFF_FFFF, 32'h1);
    check("wrap_inst_pc", o_inst_pc, 32'hFFFF_FFFF);
    i_dec_ready = 1'b1;
    step();
    i_dec_ready = 1'b0;
    check("wrap_pc", dut.pc_q, 32'h0);
    check("wrap_err_sticky", o_err, 1);

    // Reset while presenting an instruction.
    fetch_to_out(32'h90, 32'hCAFE);
    check("rout_valid", o_inst_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rout_inst_valid", o_inst_valid, 0);
    check("rout_inst", o_inst, 0);
    check("rout_inst_pc", o_inst_pc, 0);
    check("rout_err", o_err, 0);
    check("rout_ready", o_ready, 1);
    check("rout_mem_rd", o_mem_rd, 0);
    check("rout_mem_addr", o_mem_addr, 0);
    check("rout_pc_ack", o_pc_ack, 0);
    i_dec_ready = 1'b1;
    step();
    step();
    check("rout_no_inst", o_inst_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
